tff_counter_sequencer: RTL and testbench

//  - Run-control sequencer for the WIDTH-bit counters in the seq_logic library.
//  - Starts, pauses and stops a programmable-modulo count, then signals a done or wrap event.
//  - Holds the count register and the control FSM; the counter datapath sits inside this block.
//  - Downstream logic sees a fully synchronous count value, with no ripple between bits.

---
 rtl/tff_counter_sequencer.sv | 137 +++++++++++++
 tb/tb_tff_counter_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tff_counter_sequencer.sv
// Run-control sequencer with a programmable-modulo synchronous counter (one-shot or auto-reload).
// Optional down-counting via `define TFF_SEQ_DOWN_EN (adds the dir input).
module tff_counter_sequencer #(
    parameter int unsigned WIDTH         = 3,
    parameter int unsigned DEFAULT_LIMIT = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             mode,
`ifdef TFF_SEQ_DOWN_EN
    input  logic             dir,
`endif
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done,
    output logic             wrap,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             wrap_q, wrap_d;
    logic             dir_in;
    logic             term_c;
    logic [WIDTH-1:0] reload_c;
    logic [WIDTH-1:0] step_c;

`ifdef TFF_SEQ_DOWN_EN
    assign dir_in = dir;
`else
    assign dir_in = 1'b0;
`endif

    // Terminal value, reload value and next count depend on the latched direction.
    assign term_c   = dir_q ? (count_q == '0) : (count_q == limit_q);
    assign reload_c = dir_q ? limit_q : '0;
    assign step_c   = dir_q ? WIDTH'(count_q - 1'b1) : WIDTH'(count_q + 1'b1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        limit_d = limit_q;
        mode_d  = mode_q;
        dir_d   = dir_q;
        wrap_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start && !stop) begin
                    state_d = S_RUN;
                    limit_d = limit;
                    mode_d  = mode;
                    dir_d   = dir_in;
                    count_d = dir_in ? limit : '0;
                end
            end
            S_RUN: begin
                // Pause takes precedence over a terminal match; the match is re-evaluated on resume.
                if (stop) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (pause) begin
                    state_d = S_PAUSE;
                end else if (term_c) begin
                    if (mode_q) begin
                        count_d = reload_c;
                        wrap_d  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    count_d = step_c;
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    state_d = S_IDLE;
                    count_d = '0;
                end else if (!pause) begin
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_PAUSE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            count_q <= '0;
            limit_q <= WIDTH'(DEFAULT_LIMIT);
            mode_q  <= 1'b0;
            dir_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            limit_q <= limit_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign wrap  = wrap_q;
    assign state = state_q;

endmodule

// File: tb/tb_tff_counter_sequencer.sv
// Bench for tff_counter_sequencer: directed scenarios plus randomized run against a cycle model.
module tb_tff_counter_sequencer;

    logic       clk = 1'b0;
    logic       reset, start, stop, pause, mode;
    logic [2:0] limit;
    logic [2:0] count;
    logic       busy, done, wrap;
    logic [1:0] state;
`ifdef TFF_SEQ_DOWN_EN
    logic       dir;
`endif

    int tests  = 0;
    int failed = 0;

    tff_counter_sequencer #(.WIDTH(3), .DEFAULT_LIMIT(7)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .pause (pause),
        .mode  (mode),
`ifdef TFF_SEQ_DOWN_EN
        .dir   (dir),
`endif
        .limit (limit),
        .count (count),
        .busy  (busy),
        .done  (done),
        .wrap  (wrap),
        .state (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        reset = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 1'b0; limit = 3'd0;
`ifdef TFF_SEQ_DOWN_EN
        dir = 1'b0;
`endif
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tests++; if ({count, state, busy, done, wrap} !== 8'b000_00_000) begin
            failed++; $display("FAIL reset_outputs got cnt=%0d st=%0d b=%0b d=%0b w=%0b exp all zero", count, state, busy, done, wrap);
        end
        tests++; if (dut.limit_q !== 3'd7) begin
            failed++; $display("FAIL reset_limit got %0d exp 7", dut.limit_q);
        end
    endtask

    task automatic test_one_shot();
        limit = 3'd5; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; limit = 3'd1; mode = 1'b1;   // mid-run changes must be ignored
        tests++; if (count !== 3'd0 || state !== 2'd1 || busy !== 1'b1) begin
            failed++; $display("FAIL one_shot_start got cnt=%0d st=%0d b=%0b exp 0/1/1", count, state, busy);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            tests++; if (count !== 3'(i) || state !== 2'd1 || done !== 1'b0) begin
                failed++; $display("FAIL one_shot_count got cnt=%0d st=%0d exp %0d/1", count, state, i);
            end
        end
        tick();
        tests++; if (state !== 2'd3 || done !== 1'b1 || busy !== 1'b0 || count !== 3'd5) begin
            failed++; $display("FAIL one_shot_done got st=%0d d=%0b b=%0b cnt=%0d exp 3/1/0/5", state, done, busy, count);
        end
        start = 1'b1;   // DONE always returns to IDLE
        tick();
        start = 1'b0;
        tests++; if (state !== 2'd0 || done !== 1'b0 || count !== 3'd5) begin
            failed++; $display("FAIL one_shot_idle got st=%0d d=%0b cnt=%0d exp 0/0/5", state, done, count);
        end
    endtask

    task automatic test_auto_reload();
        logic [2:0] exp_c [6] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2};
        limit = 3'd2; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            tests++; if (count !== exp_c[i] || wrap !== (i == 3) || state !== 2'd1) begin
                failed++; $display("FAIL auto_reload[%0d] got cnt=%0d w=%0b st=%0d exp %0d/%0b/1", i, count, wrap, state, exp_c[i], (i == 3));
            end
        end
        tick();
        tests++; if (count !== 3'd0 || wrap !== 1'b1) begin
            failed++; $display("FAIL auto_reload_wrap2 got cnt=%0d w=%0b exp 0/1", count, wrap);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
        tests++; if (state !== 2'd0 || count !== 3'd0 || busy !== 1'b0 || wrap !== 1'b0) begin
            failed++; $display("FAIL auto_reload_stop got st=%0d cnt=%0d b=%0b w=%0b exp 0/0/0/0", state, count, busy, wrap);
        end
    endtask

    task automatic test_pause();
        limit = 3'd7; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        pause = 1'b1;
        for (int i = 0; i < 3; i++) begin
            start = (i == 1);
            tick();
            tests++; if (count !== 3'd3 || state !== 2'd2 || busy !== 1'b1) begin
                failed++; $display("FAIL pause_hold got cnt=%0d st=%0d b=%0b exp 3/2/1", count, state, busy);
            end
        end
        pause = 1'b0; start = 1'b0;
        tick();
        tests++; if (count !== 3'd3 || state !== 2'd1) begin
            failed++; $display("FAIL pause_resume got cnt=%0d st=%0d exp 3/1", count, state);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        tests++; if (count !== 3'd4 || state !== 2'd1) begin
            failed++; $display("FAIL pause_after got cnt=%0d st=%0d exp 4/1", count, state);
        end
        tick(); tick(); tick();   // reaches 7
        pause = 1'b1;             // terminal match while paused: pause wins
        tick();
        tests++; if (state !== 2'd2 || done !== 1'b0 || count !== 3'd7) begin
            failed++; $display("FAIL pause_at_term got st=%0d d=%0b cnt=%0d exp 2/0/7", state, done, count);
        end
        pause = 1'b0;
        tick(); tick();
        tests++; if (state !== 2'd3 || done !== 1'b1 || count !== 3'd7) begin
            failed++; $display("FAIL pause_term_done got st=%0d d=%0b cnt=%0d exp 3/1/7", state, done, count);
        end
        tick();
    endtask

    task automatic test_edge_cases();
        limit = 3'd0; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tests++; if (state !== 2'd3 || done !== 1'b1 || count !== 3'd0) begin
            failed++; $display("FAIL limit0_oneshot got st=%0d d=%0b cnt=%0d exp 3/1/0", state, done, count);
        end
        tick();
        limit = 3'd0; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (count !== 3'd0 || wrap !== 1'b1 || state !== 2'd1) begin
                failed++; $display("FAIL limit0_auto got cnt=%0d w=%0b st=%0d exp 0/1/1", count, wrap, state);
            end
        end
        stop = 1'b1; start = 1'b1;
        tick();
        stop = 1'b0; start = 1'b0;
        tests++; if (state !== 2'd0 || count !== 3'd0 || busy !== 1'b0) begin
            failed++; $display("FAIL stop_start got st=%0d cnt=%0d b=%0b exp 0/0/0", state, count, busy);
        end
        limit = 3'd3; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if ({count, state, busy, done, wrap} !== 8'b000_00_000 || dut.limit_q !== 3'd7) begin
            failed++; $display("FAIL reset_midrun got cnt=%0d st=%0d b=%0b lim=%0d exp 0/0/0/7", count, state, busy, dut.limit_q);
        end
    endtask

`ifdef TFF_SEQ_DOWN_EN
    task automatic test_down();
        dir = 1'b1; limit = 3'd4; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0; dir = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (i < 4) tick();
            tests++; if (count !== 3'(i) || state !== 2'd1) begin
                failed++; $display("FAIL down_count got cnt=%0d st=%0d exp %0d/1", count, state, i);
            end
        end
        tick();
        tests++; if (done !== 1'b1 || count !== 3'd0) begin
            failed++; $display("FAIL down_done got d=%0b cnt=%0d exp 1/0", done, count);
        end
        tick();
        dir = 1'b1; mode = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; dir = 1'b0;
        tick(); tick(); tick(); tick(); tick();
        tests++; if (count !== 3'd4 || wrap !== 1'b1) begin
            failed++; $display("FAIL down_reload got cnt=%0d w=%0b exp 4/1", count, wrap);
        end
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask
`endif

    // Randomized stimulus checked against a behavioural cycle model of the sequencer rules.
    task automatic test_random();
        int m_ph = 0, m_cnt = 0, m_lim = 7, m_mode = 0;
        bit m_wrap;
        reset = 1'b1;
        tick();
        for (int cyc = 0; cyc < 600; cyc++) begin
            reset = ($urandom_range(0, 79) == 0);
            start = ($urandom_range(0, 2) == 0);
            stop  = !start && ($urandom_range(0, 11) == 0);
            pause = ($urandom_range(0, 3) == 0);
            mode  = 1'($urandom_range(0, 1));
            limit = 3'($urandom_range(0, 7));
            m_wrap = 1'b0;
            if (reset) begin
                m_ph = 0; m_cnt = 0; m_lim = 7; m_mode = 0;
            end else if (m_ph == 0) begin
                if (start) begin m_ph = 1; m_cnt = 0; m_lim = int'(limit); m_mode = int'(mode); end
            end else if (m_ph == 3) begin
                m_ph = 0;
            end else if (stop) begin
                m_ph = 0; m_cnt = 0;
            end else if (m_ph == 2) begin
                if (!pause) m_ph = 1;
            end else if (pause) begin
                m_ph = 2;
            end else if (m_cnt == m_lim && m_mode == 0) begin
                m_ph = 3;
            end else begin
                m_wrap = (m_cnt == m_lim);
                m_cnt  = (m_cnt + 1) % (m_lim + 1);
            end
            tick();
            tests++; if (count !== 3'(m_cnt) || state !== 2'(m_ph)) begin
                failed++; $display("FAIL rand_cnt_state cyc=%0d got %0d/%0d exp %0d/%0d", cyc, count, state, m_cnt, m_ph);
            end
            tests++; if (busy !== (m_ph == 1 || m_ph == 2) || done !== (m_ph == 3) || wrap !== m_wrap) begin
                failed++; $display("FAIL rand_flags cyc=%0d got b=%0b d=%0b w=%0b exp %0b/%0b/%0b", cyc, busy, done, wrap, (m_ph == 1 || m_ph == 2), (m_ph == 3), m_wrap);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_auto_reload();
        test_pause();
        test_edge_cases();
`ifdef TFF_SEQ_DOWN_EN
        test_down();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
